// File: rtl/pwm_source_arbiter.sv
// pwm_source_arbiter
//   Chooses, per servo channel, between the RC receiver and the SD-card
//   autopilot as the source of the PWM pulse-width word. The operating mode
//   (MANUAL / CRITICAL / AUTO / FAILSAFE) comes from two debounced pilot
//   switches and from a receiver-loss watchdog. Mode and outputs only change
//   on a frame_tick, so a PWM frame is never split between two sources.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous active-high reset
//   auto_req_i     raw autopilot switch (asynchronous)
//   critical_req_i raw critical-mode switch (asynchronous)
//   rec_data_i     receiver words, channel i at [i*WIDTH +: WIDTH]
//   rec_valid_i    one-cycle strobe, rec_data_i holds a new frame
//   sd_data_i      autopilot words, same packing
//   sd_valid_i     one-cycle strobe, sd_data_i holds a new frame
//   frame_tick_i   one-cycle strobe at the start of each output frame
//   out_data_o     registered arbitrated words
//   mode_o         00 MANUAL, 01 CRITICAL, 10 AUTO, 11 FAILSAFE
//   rec_lost_o     receiver watchdog saturated
module pwm_source_arbiter #(
    parameter int                 NUM_CH      = 6,
    parameter int                 WIDTH       = 12,
    parameter int                 DEBOUNCE    = 3,
    parameter int                 REC_TIMEOUT = 50000,
    parameter int                 NEUTRAL     = 1500,
    parameter logic [NUM_CH-1:0]  MANUAL_MASK = 6'b110000,
    parameter logic [NUM_CH-1:0]  CRIT_MASK   = 6'b001001,
    parameter logic [NUM_CH-1:0]  AUTO_MASK   = 6'b111111
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    auto_req_i,
    input  logic                    critical_req_i,
    input  logic [NUM_CH*WIDTH-1:0] rec_data_i,
    input  logic                    rec_valid_i,
    input  logic [NUM_CH*WIDTH-1:0] sd_data_i,
    input  logic                    sd_valid_i,
    input  logic                    frame_tick_i,
    output logic [NUM_CH*WIDTH-1:0] out_data_o,
    output logic [1:0]              mode_o,
    output logic                    rec_lost_o
);

    typedef enum logic [1:0] {
        MODE_MANUAL   = 2'b00,
        MODE_CRITICAL = 2'b01,
        MODE_AUTO     = 2'b10,
        MODE_FAILSAFE = 2'b11
    } mode_e;

    localparam int                       CNT_W       = $clog2(DEBOUNCE + 1);
    localparam int                       TMR_W       = $clog2(REC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]         DEB_MAX     = CNT_W'(DEBOUNCE);
    localparam logic [TMR_W-1:0]         TMR_MAX     = TMR_W'(REC_TIMEOUT);
    localparam logic [WIDTH-1:0]         NEUTRAL_W   = WIDTH'(NEUTRAL);
    localparam logic [NUM_CH*WIDTH-1:0]  NEUTRAL_BUS = {NUM_CH{NEUTRAL_W}};

    logic                    auto_s1_q, auto_s2_q, crit_s1_q, crit_s2_q;
    logic [NUM_CH*WIDTH-1:0] rec_hold_q, sd_hold_q;
    logic [NUM_CH*WIDTH-1:0] out_data_q, out_data_d;
    logic [TMR_W-1:0]        timer_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    mode_e                   mode_q, mode_d, cand_q, cand_d, req_mode;
    logic                    rec_lost;
    logic                    deb_done;
    logic [NUM_CH-1:0]       sel_mask;

    // Two-flop synchronisers for the pilot switches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            auto_s1_q <= 1'b0;
            auto_s2_q <= 1'b0;
            crit_s1_q <= 1'b0;
            crit_s2_q <= 1'b0;
        end else begin
            auto_s1_q <= auto_req_i;
            auto_s2_q <= auto_s1_q;
            crit_s1_q <= critical_req_i;
            crit_s2_q <= crit_s1_q;
        end
    end

    // Source holding registers and receiver watchdog. A valid strobe wins
    // over saturation, so rec_lost falls the cycle after a frame arrives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rec_hold_q <= NEUTRAL_BUS;
            sd_hold_q  <= NEUTRAL_BUS;
            timer_q    <= '0;
        end else begin
            if (rec_valid_i) rec_hold_q <= rec_data_i;
            if (sd_valid_i)  sd_hold_q  <= sd_data_i;
            if (rec_valid_i)
                timer_q <= '0;
            else if (timer_q != TMR_MAX)
                timer_q <= timer_q + 1'b1;
        end
    end

    assign rec_lost = (timer_q == TMR_MAX);

    // Auto switch dominates the critical switch.
    always_comb begin
        req_mode = MODE_MANUAL;
        if (auto_s2_q)
            req_mode = MODE_AUTO;
        else if (crit_s2_q)
            req_mode = MODE_CRITICAL;
    end

    // Debounce candidate/counter, advanced only once per frame.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (frame_tick_i) begin
            if (req_mode == cand_q) begin
                if (cnt_q != DEB_MAX) cnt_d = cnt_q + 1'b1;
            end else begin
                cand_d = req_mode;
                cnt_d  = CNT_W'(1);
            end
        end
    end

    // Counter saturates at DEBOUNCE, so equality means "held long enough".
    assign deb_done = (cnt_d == DEB_MAX);

    // Mode transitions. Receiver loss forces FAILSAFE from the pilot-flown
    // modes only; the autopilot does not need the receiver.
    always_comb begin
        mode_d = mode_q;
        if (frame_tick_i) begin
            case (mode_q)
                MODE_MANUAL, MODE_CRITICAL: begin
                    if (rec_lost)
                        mode_d = MODE_FAILSAFE;
                    else if (deb_done && cand_d != mode_q)
                        mode_d = cand_d;
                end
                MODE_AUTO: begin
                    if (deb_done && cand_d != mode_q)
                        mode_d = cand_d;
                end
                MODE_FAILSAFE: begin
                    if (!rec_lost && deb_done)
                        mode_d = cand_d;
                end
                default: mode_d = MODE_MANUAL;
            endcase
        end
    end

    // Per-channel mux driven by the mode that takes effect this frame; the
    // holding registers are read before any same-cycle valid update.
    always_comb begin
        case (mode_d)
            MODE_MANUAL:   sel_mask = MANUAL_MASK;
            MODE_CRITICAL: sel_mask = CRIT_MASK;
            MODE_AUTO:     sel_mask = AUTO_MASK;
            default:       sel_mask = '1;
        endcase
        out_data_d = out_data_q;
        if (frame_tick_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                out_data_d[i*WIDTH +: WIDTH] = sel_mask[i] ? sd_hold_q[i*WIDTH +: WIDTH]
                                                           : rec_hold_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // Mode FSM state and its registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q     <= MODE_MANUAL;
            cand_q     <= MODE_MANUAL;
            cnt_q      <= DEB_MAX;
            out_data_q <= NEUTRAL_BUS;
        end else begin
            mode_q     <= mode_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data_o = out_data_q;
    assign mode_o     = mode_q;
    assign rec_lost_o = rec_lost;

endmodule
